// File: rtl/ram_sync_dp.sv
// Simple dual-port RAM with registered read, per-byte write enables, collision policy and a
// post-reset zero-fill sequencer. Define RAM_SYNC_DP_OUT_REG_EN for a second output stage (latency 2).
module ram_sync_dp #(
  parameter int NB_DATA     = 16,
  parameter int NB_BYTE     = 8,
  parameter int NB_ADDR     = 10,
  parameter int RAM_DEPTH   = 2**NB_ADDR,
  parameter int WRITE_FIRST = 0
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_write_enable,
  input  logic [NB_DATA/NB_BYTE-1:0] i_byte_enable,
  input  logic [NB_ADDR-1:0]         i_write_address,
  input  logic [NB_DATA-1:0]         i_data,
  input  logic                       i_read_enable,
  input  logic [NB_ADDR-1:0]         i_read_address,
  output logic [NB_DATA-1:0]         o_data,
  output logic                       o_read_valid,
  output logic                       o_busy
);

  localparam int                 NB_LANES  = NB_DATA / NB_BYTE;
  localparam logic [NB_ADDR:0]   DEPTH     = (NB_ADDR+1)'(RAM_DEPTH);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(RAM_DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t               state_q;
  logic [NB_ADDR-1:0]   clr_cnt_q;
  logic [NB_DATA-1:0]   rd_data_q;
  logic                 rd_valid_q;
  logic [NB_DATA-1:0]   rd_data_d;

  logic [NB_DATA-1:0]   mem [RAM_DEPTH];

  logic                 wr_in_range;
  logic                 rd_in_range;
  logic                 write_hit;
  logic                 mem_we;
  logic [NB_ADDR-1:0]   mem_addr;
  logic [NB_DATA-1:0]   mem_wdata;
  logic [NB_LANES-1:0]  mem_be;

  assign wr_in_range = {1'b0, i_write_address} < DEPTH;
  assign rd_in_range = {1'b0, i_read_address} < DEPTH;
  assign write_hit   = i_write_enable && wr_in_range && (i_write_address == i_read_address);

  // The clear sequencer owns the single write port while busy.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value undriven (no latches).
    mem_we    = 1'b0;
    mem_addr  = i_write_address;
    mem_wdata = i_data;
    mem_be    = i_byte_enable;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_cnt_q;
      mem_wdata = '0;
      mem_be    = '1;
    end else if (i_write_enable && wr_in_range) begin
      mem_we = 1'b1;
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_in_range) begin
      rd_data_d = mem[i_read_address];
      if ((WRITE_FIRST != 0) && write_hit) begin
        for (int k = 0; k < NB_LANES; k++) begin
          // NOTE: blocking assignments in combinational logic, so later lanes see earlier updates.
          if (i_byte_enable[k]) rd_data_d[k*NB_BYTE +: NB_BYTE] = i_data[k*NB_BYTE +: NB_BYTE];
        end
      end
    end
  end

  // NOTE: the array has no reset; clearing it is the sequencer's job, which keeps it mappable to RAM.
  always_ff @(posedge i_clock) begin
    if (mem_we) begin
      for (int k = 0; k < NB_LANES; k++) begin
        if (mem_be[k]) mem[mem_addr][k*NB_BYTE +: NB_BYTE] <= mem_wdata[k*NB_BYTE +: NB_BYTE];
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (state_q == ST_CLEAR) begin
      rd_valid_q <= 1'b0;
      clr_cnt_q  <= clr_cnt_q + NB_ADDR'(1);
      if (clr_cnt_q == LAST_ADDR) state_q <= ST_RUN;
    end else begin
      rd_valid_q <= i_read_enable;
      if (i_read_enable) rd_data_q <= rd_data_d;
    end
  end

  assign o_busy = (state_q == ST_CLEAR);

`ifdef RAM_SYNC_DP_OUT_REG_EN
  logic [NB_DATA-1:0] out_data_q;
  logic               out_valid_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= rd_data_q;
      out_valid_q <= rd_valid_q;
    end
  end

  assign o_data       = out_data_q;
  assign o_read_valid = out_valid_q;
`else
  assign o_data       = rd_data_q;
  assign o_read_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_ram_sync_dp.sv
// Bench for ram_sync_dp: three instances (depth 16 read-first, depth 16 write-first, depth 12)
// share directed and random stimulus and are compared every cycle against an array-based model.
module tb_ram_sync_dp;

  localparam int NI = 3;
`ifdef RAM_SYNC_DP_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_write_enable;
  logic [1:0]        i_byte_enable;
  logic [3:0]        i_write_address;
  logic [15:0]       i_data;
  logic              i_read_enable;
  logic [3:0]        i_read_address;
  logic [NI-1:0][15:0] odata;
  logic [NI-1:0]     ovalid;
  logic [NI-1:0]     obusy;

  always #5 clk = ~clk;

  ram_sync_dp #(.NB_DATA(16), .NB_BYTE(8), .NB_ADDR(4), .RAM_DEPTH(16), .WRITE_FIRST(0)) u_rf (
    .i_clock(clk), .i_reset(rst), .i_write_enable(i_write_enable), .i_byte_enable(i_byte_enable),
    .i_write_address(i_write_address), .i_data(i_data), .i_read_enable(i_read_enable),
    .i_read_address(i_read_address), .o_data(odata[0]), .o_read_valid(ovalid[0]), .o_busy(obusy[0]));

  ram_sync_dp #(.NB_DATA(16), .NB_BYTE(8), .NB_ADDR(4), .RAM_DEPTH(16), .WRITE_FIRST(1)) u_wf (
    .i_clock(clk), .i_reset(rst), .i_write_enable(i_write_enable), .i_byte_enable(i_byte_enable),
    .i_write_address(i_write_address), .i_data(i_data), .i_read_enable(i_read_enable),
    .i_read_address(i_read_address), .o_data(odata[1]), .o_read_valid(ovalid[1]), .o_busy(obusy[1]));

  ram_sync_dp #(.NB_DATA(16), .NB_BYTE(8), .NB_ADDR(4), .RAM_DEPTH(12), .WRITE_FIRST(0)) u_d12 (
    .i_clock(clk), .i_reset(rst), .i_write_enable(i_write_enable), .i_byte_enable(i_byte_enable),
    .i_write_address(i_write_address), .i_data(i_data), .i_read_enable(i_read_enable),
    .i_read_address(i_read_address), .o_data(odata[2]), .o_read_valid(ovalid[2]), .o_busy(obusy[2]));

  // Reference model: per-instance memory image, first read stage, optional second stage, clear countdown.
  int          depth_m [NI] = '{16, 16, 12};
  bit          wf_m    [NI] = '{1'b0, 1'b1, 1'b0};
  logic [15:0] mem_m   [NI][16];
  logic [15:0] s1_d    [NI];
  logic        s1_v    [NI];
  logic [15:0] out_d   [NI];
  logic        out_v   [NI];
  int          busy_left [NI];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    logic [15:0] m;
    m = {{8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int a = 0; a < 16; a++) mem_m[i][a] = 16'h0;
      s1_d[i] = 16'h0; s1_v[i] = 1'b0;
      out_d[i] = 16'h0; out_v[i] = 1'b0;
      busy_left[i] = depth_m[i];
    end
  endtask

  task automatic cycle(input logic we, input logic [1:0] be, input logic [3:0] wa,
                       input logic [15:0] d, input logic re, input logic [3:0] ra);
    logic [15:0] rv, nv, exp_d;
    logic        exp_v;
    i_write_enable  = we;
    i_byte_enable   = be;
    i_write_address = wa;
    i_data          = d;
    i_read_enable   = re;
    i_read_address  = ra;
    for (int i = 0; i < NI; i++) begin
      out_d[i] = s1_d[i];
      out_v[i] = s1_v[i];
      if (busy_left[i] > 0) begin
        busy_left[i]--;
        s1_v[i] = 1'b0;
      end else begin
        rv = (int'(ra) < depth_m[i]) ? mem_m[i][ra] : 16'h0;
        if (we && int'(wa) < depth_m[i]) begin
          nv = merge(mem_m[i][wa], d, be);
          if (re && wf_m[i] && wa == ra) rv = nv;
          mem_m[i][wa] = nv;
        end
        s1_v[i] = re;
        if (re) s1_d[i] = rv;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      exp_d = (LAT == 2) ? out_d[i] : s1_d[i];
      exp_v = (LAT == 2) ? out_v[i] : s1_v[i];
      check($sformatf("data[%0d]@%0t", i, $time), 32'(odata[i]), 32'(exp_d));
      check($sformatf("valid[%0d]@%0t", i, $time), 32'(ovalid[i]), 32'(exp_v));
      check($sformatf("busy[%0d]@%0t", i, $time), 32'(obusy[i]), 32'(busy_left[i] > 0));
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) cycle(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 4'd0);
  endtask

  task automatic do_reset(input int n);
    i_write_enable = 1'b0;
    i_read_enable  = 1'b0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_data[%0d]", i), 32'(odata[i]), 32'h0);
      check($sformatf("rst_valid[%0d]", i), 32'(ovalid[i]), 32'h0);
      check($sformatf("rst_busy[%0d]", i), 32'(obusy[i]), 32'h1);
    end
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic        we, re;
    logic [1:0]  be;
    logic [3:0]  wa, ra;
    rst = 1'b0;
    i_write_enable = 1'b0; i_byte_enable = 2'b00; i_write_address = 4'd0;
    i_data = 16'h0; i_read_enable = 1'b0; i_read_address = 4'd0;

    // Clear after reset; writes during CLEAR are ignored.
    do_reset(2);
    for (int c = 0; c < 8; c++) cycle(1'b1, 2'b11, 4'd3, 16'hBEEF, 1'b0, 4'd0);
    idle(8);
    cycle(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd3);
    idle(2);

    // Reset halfway through CLEAR.
    do_reset(2);
    idle(8);
    do_reset(2);
    idle(16);

    // Byte enables.
    cycle(1'b1, 2'b11, 4'd5, 16'h1234, 1'b0, 4'd0);
    cycle(1'b1, 2'b01, 4'd5, 16'hABCD, 1'b0, 4'd0);
    cycle(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd5);
    cycle(1'b1, 2'b00, 4'd5, 16'hFFFF, 1'b0, 4'd0);
    cycle(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd5);
    idle(2);

    // Collision at address 7.
    cycle(1'b1, 2'b11, 4'd7, 16'h00FF, 1'b0, 4'd0);
    cycle(1'b1, 2'b10, 4'd7, 16'hAA55, 1'b1, 4'd7);
    cycle(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd7);
    idle(2);

    // Streaming: write address*3, read back-to-back.
    for (int a = 0; a < 16; a++) cycle(1'b1, 2'b11, 4'(a), 16'(a * 3), 1'b0, 4'd0);
    for (int a = 0; a < 16; a++) cycle(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'(a));
    idle(2);

    // Reset in RUN after writing address 2.
    cycle(1'b1, 2'b11, 4'd2, 16'h5555, 1'b0, 4'd0);
    cycle(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd2);
    do_reset(2);
    idle(16);
    cycle(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd2);
    idle(2);

    // Out-of-range on the depth-12 instance.
    cycle(1'b1, 2'b11, 4'd11, 16'h1111, 1'b0, 4'd0);
    cycle(1'b1, 2'b11, 4'd13, 16'h7777, 1'b0, 4'd0);
    cycle(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd13);
    cycle(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd11);
    idle(2);

    // Random traffic with biased collisions and occasional resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1 + $urandom_range(0, 2));
      end else begin
        we = 1'($urandom);
        re = 1'($urandom);
        be = 2'($urandom);
        ra = 4'($urandom);
        wa = ($urandom_range(0, 2) == 0) ? ra : 4'($urandom);
        cycle(we, be, wa, 16'($urandom), re, ra);
      end
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
